// File: rtl/control_ajuste_botones_if.sv
// rtl/control_ajuste_botones_if.sv - raw button/switch inputs and counter-control outputs
interface control_ajuste_botones_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_formato;
  logic       sw_config;
  logic       enUP;
  logic       enDOWN;
  logic [3:0] en_count;
  logic       formato_hora;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_formato, sw_config,
    input  enUP, enDOWN, en_count, formato_hora
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_formato, sw_config,
    output enUP, enDOWN, en_count, formato_hora
  );
endinterface

// File: rtl/control_ajuste_botones.sv
// rtl/control_ajuste_botones.sv - button conditioning and field-select FSM for the time-setting path
module control_ajuste_botones #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic                      clk,
  input  logic                      reset,
  control_ajuste_botones_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int UP = 0;
  localparam int DN = 1;
  localparam int LF = 2;
  localparam int RT = 3;
  localparam int FM = 4;
  localparam int SW = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, SEG = 2'd1, MIN = 2'd2, HOR = 2'd3} state_t;

  logic [5:0]    raw;
  logic [5:0]    sync1_q, sync2_q, prev_q;
  logic [5:0]    db_q, db_d;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];
  logic [2:0]    edge_prev_q;
  logic          tick_l, tick_r, tick_f;

  state_t        state_q, state_d;
  logic          enup_q, endown_q, fmt_q;
  logic [3:0]    en_count_q;

  assign raw = {bus.sw_config, bus.btn_formato, bus.btn_right,
                bus.btn_left, bus.btn_down, bus.btn_up};

  // Count only while the synchronized level disagrees with the debounced one and holds still.
  always_comb begin
    db_d = db_q;
    for (int c = 0; c < 6; c++) begin
      cnt_d[c] = '0;
      if ((sync2_q[c] != db_q[c]) && (sync2_q[c] == prev_q[c])) begin
        if (cnt_q[c] == CNT_LAST) db_d[c] = sync2_q[c];
        else                      cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      db_q        <= '0;
      edge_prev_q <= '0;
      for (int c = 0; c < 6; c++) cnt_q[c] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      db_q        <= db_d;
      edge_prev_q <= db_q[FM:LF];
      for (int c = 0; c < 6; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign tick_l = db_q[LF] & ~edge_prev_q[0];
  assign tick_r = db_q[RT] & ~edge_prev_q[1];
  assign tick_f = db_q[FM] & ~edge_prev_q[2];

  always_comb begin
    state_d = state_q;
    if (!db_q[SW]) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SEG;
        SEG: begin
          if (tick_r && !tick_l)      state_d = MIN;
          else if (tick_l && !tick_r) state_d = HOR;
        end
        MIN: begin
          if (tick_r && !tick_l)      state_d = HOR;
          else if (tick_l && !tick_r) state_d = SEG;
        end
        HOR: begin
          if (tick_r && !tick_l)      state_d = SEG;
          else if (tick_l && !tick_r) state_d = MIN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Enables look at the next state so leaving adjustment drops them with en_count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      en_count_q <= '0;
      enup_q     <= 1'b0;
      endown_q   <= 1'b0;
      fmt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_count_q <= {2'b00, state_d};
      enup_q     <= db_q[UP] & ~db_q[DN] & (state_d != IDLE);
      endown_q   <= db_q[DN] & ~db_q[UP] & (state_d != IDLE);
      fmt_q      <= fmt_q ^ tick_f;
    end
  end

  assign bus.enUP         = enup_q;
  assign bus.enDOWN       = endown_q;
  assign bus.en_count     = en_count_q;
  assign bus.formato_hora = fmt_q;

endmodule
